// File: rtl/imm_ext_stage.sv
// rtl/imm_ext_stage.sv - registered immediate-extension stage with 2-entry output buffer
module imm_ext_stage #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);
    localparam int PAD = OUT_W - IN_W;

    logic [OUT_W-1:0] data_q [2];
    logic [TAG_W-1:0] tag_q  [2];
    logic [1:0]       ill_q;
    logic [1:0]       count_q, count_d;
    logic             head_q, head_d;

    logic             push, pop, wr_idx;
    logic [OUT_W-1:0] sext, ext_data;
    logic             ext_ill;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // Tail slot: head when empty, the other slot when one entry is held.
    assign wr_idx    = head_q ^ count_q[0];

    assign sext = {{PAD{in_imm[IN_W-1]}}, in_imm};

    always_comb begin
        ext_data = '0;
        ext_ill  = 1'b0;
        case (in_op)
            3'd0:    ext_data = sext;
            3'd1:    ext_data = {{PAD{1'b0}}, in_imm};
            3'd2:    ext_data = {in_imm, {PAD{1'b0}}};
            3'd3:    ext_data = {sext[OUT_W-3:0], 2'b00};
            default: ext_ill  = 1'b1;
        endcase
    end

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        if (flush) begin
            count_d = 2'd0;
            head_d  = 1'b0;
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01: begin
                    count_d = count_q - 2'd1;
                    head_d  = ~head_q;
                end
                2'b11:   head_d  = ~head_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            ill_q   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            if (push && !flush) begin
                data_q[wr_idx] <= ext_data;
                tag_q[wr_idx]  <= in_tag;
                ill_q[wr_idx]  <= ext_ill;
            end
        end
    end

    assign out_data    = data_q[head_q];
    assign out_tag     = tag_q[head_q];
    assign out_illegal = ill_q[head_q];
endmodule

// File: tb/tb_imm_ext_stage.sv
// tb/tb_imm_ext_stage.sv - randomized self-checking bench for imm_ext_stage
module tb_imm_ext_stage;
    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm = '0;
    logic [2:0]       in_op = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic [TAG_W-1:0] t;
        logic             i;
    } ent_t;

    ent_t q[$];

    imm_ext_stage #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm),
        .in_op(in_op), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Arithmetic reference: interpret the immediate as a signed integer, then wrap modulo 2^OUT_W.
    function automatic ent_t ref_ext(logic [IN_W-1:0] imm, logic [2:0] op, logic [TAG_W-1:0] tg);
        ent_t   r;
        longint s, v, m;
        m = longint'(1) << OUT_W;
        s = longint'(imm);
        if (s >= (longint'(1) << (IN_W - 1))) s = s - (longint'(1) << IN_W);
        r.i = 1'b0;
        case (op)
            3'd0:    v = s;
            3'd1:    v = longint'(imm);
            3'd2:    v = longint'(imm) * (longint'(1) << (OUT_W - IN_W));
            3'd3:    v = s * 4;
            default: begin v = 0; r.i = 1'b1; end
        endcase
        v = v & (m - 1);
        r.d = v[OUT_W-1:0];
        r.t = tg;
        return r;
    endfunction

    // Drive one cycle from a negedge; the model follows the handshake rules at the posedge.
    task automatic step(input logic v, input logic [IN_W-1:0] imm, input logic [2:0] op,
                        input logic [TAG_W-1:0] tg, input logic ordy, input logic fl);
        bit do_push, do_pop;
        in_valid = v; in_imm = imm; in_op = op; in_tag = tg; out_ready = ordy; flush = fl;
        do_push = v && (q.size() < 2);
        do_pop  = (q.size() != 0) && ordy;
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(ref_ext(imm, op, tg));
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, in_ready, out_data, out_tag, out_illegal} !== {1'b0, 1'b1, {OUT_W{1'b0}}, {TAG_W{1'b0}}, 1'b0}) begin
            failures++;
            $display("FAIL reset_values: valid=%0b ready=%0b data=%h tag=%0d ill=%0b required 0/1/0/0/0",
                     out_valid, in_ready, out_data, out_tag, out_illegal);
        end
        reset_n = 1'b1;
        q.delete();
        @(negedge clk);
    endtask

    task automatic test_single();
        step(1'b1, 16'h8001, 3'd0, 5'd3, 1'b1, 1'b0);
        checks++;
        if ({out_valid, out_data, out_tag, out_illegal} !== {1'b1, 32'hFFFF8001, 5'd3, 1'b0}) begin
            failures++;
            $display("FAIL single_sign: valid=%0b data=%h tag=%0d ill=%0b required 1/ffff8001/3/0",
                     out_valid, out_data, out_tag, out_illegal);
        end
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drain: out_valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_modes();
        logic [2:0]       ops [4]  = '{3'd1, 3'd2, 3'd3, 3'd5};
        logic [OUT_W-1:0] exps [4] = '{32'h00008001, 32'h80010000, 32'hFFFE0004, 32'h0};
        logic             ills [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 16'h8001, ops[k], TAG_W'(k + 4), 1'b0, 1'b0);
            checks++;
            if ({out_valid, out_data, out_illegal, out_tag} !== {1'b1, exps[k], ills[k], TAG_W'(k + 4)}) begin
                failures++;
                $display("FAIL mode_op%0d: valid=%0b data=%h ill=%0b tag=%0d required 1/%h/%0b/%0d",
                         ops[k], out_valid, out_data, out_illegal, out_tag, exps[k], ills[k], k + 4);
            end
            step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_backpressure();
        logic [OUT_W-1:0] d0;
        int got[$];
        bit pending;
        step(1'b1, 16'($urandom), 3'($urandom_range(0, 3)), 5'd1, 1'b0, 1'b0);
        d0 = out_data;
        checks++;
        if (d0 !== q[0].d) begin
            failures++;
            $display("FAIL bp_first_data: data=%h required %h", d0, q[0].d);
        end
        step(1'b1, 16'($urandom), 3'($urandom_range(0, 3)), 5'd2, 1'b0, 1'b0);
        checks++;
        if ({in_ready, out_tag, out_data} !== {1'b0, 5'd1, d0}) begin
            failures++;
            $display("FAIL bp_full: ready=%0b tag=%0d data=%h required 0/1/%h", in_ready, out_tag, out_data, d0);
        end
        step(1'b1, 16'($urandom), 3'($urandom_range(0, 3)), 5'd3, 1'b0, 1'b0);
        checks++;
        if ({in_ready, out_tag, out_data} !== {1'b0, 5'd1, d0}) begin
            failures++;
            $display("FAIL bp_hold: ready=%0b tag=%0d data=%h required 0/1/%h", in_ready, out_tag, out_data, d0);
        end
        pending = 1'b1;
        for (int c = 0; c < 10 && (pending || q.size() != 0); c++) begin
            checks++;
            if (out_valid !== (q.size() != 0) || (q.size() != 0 && out_tag !== q[0].t)) begin
                failures++;
                $display("FAIL bp_drain_head: valid=%0b tag=%0d required %0b/%0d", out_valid, out_tag,
                         q.size() != 0, q.size() != 0 ? q[0].t : 0);
            end
            if (out_valid) got.push_back(int'(out_tag));
            if (pending && q.size() < 2) begin
                step(1'b1, 16'h1234, 3'd1, 5'd3, 1'b1, 1'b0);
                pending = 1'b0;
            end else step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        end
        checks++;
        if (got.size() != 3 || got[0] != 1 || got[1] != 2 || got[2] != 3) begin
            failures++;
            $display("FAIL bp_order: got %0d tags (%p) required 1,2,3", got.size(), got);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 16'($urandom), 3'($urandom_range(0, 7)), 5'd0, 1'b1, 1'b0);
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if ({out_valid, in_ready} !== 2'b11 || q.size() != 1 ||
                {out_data, out_tag, out_illegal} !== {q[0].d, q[0].t, q[0].i}) begin
                failures++;
                $display("FAIL b2b_cycle%0d: valid=%0b ready=%0b data=%h tag=%0d required 1/1/%h/%0d",
                         c, out_valid, in_ready, out_data, out_tag, q[0].d, q[0].t);
            end
            step(1'b1, 16'($urandom), 3'($urandom_range(0, 7)), TAG_W'(c), 1'b1, 1'b0);
        end
        step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: out_valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_flush();
        step(1'b1, 16'($urandom), 3'd0, 5'd10, 1'b0, 1'b0);
        step(1'b1, 16'($urandom), 3'd0, 5'd11, 1'b0, 1'b0);
        step(1'b1, 16'($urandom), 3'd0, 5'd12, 1'b1, 1'b1);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL flush_state: valid=%0b ready=%0b required 0/1", out_valid, in_ready);
        end
        for (int c = 0; c < 20; c++) begin
            if (out_valid) begin
                checks++;
                if (out_tag inside {5'd10, 5'd11, 5'd12} || q.size() == 0 || out_tag !== q[0].t) begin
                    failures++;
                    $display("FAIL flush_leak: tag=%0d required %0d", out_tag, q.size() != 0 ? q[0].t : 0);
                end
            end
            step(c < 15, 16'($urandom), 3'($urandom_range(0, 7)), TAG_W'(20 + c), 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic test_async_reset();
        while (q.size() != 0) step(1'b0, '0, '0, '0, 1'b1, 1'b0);
        step(1'b1, 16'hFFFF, 3'd0, 5'd7, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre: out_valid=%0b required 1", out_valid);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, out_data, out_tag, out_illegal} !== {1'b0, 1'b1, {OUT_W{1'b0}}, {TAG_W{1'b0}}, 1'b0}) begin
            failures++;
            $display("FAIL areset_immediate: valid=%0b ready=%0b data=%h tag=%0d ill=%0b required 0/1/0/0/0",
                     out_valid, in_ready, out_data, out_tag, out_illegal);
        end
        q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, 16'h0003, 3'd3, 5'd9, 1'b0, 1'b0);
        checks++;
        if ({out_valid, out_data, out_tag} !== {1'b1, 32'h0000000C, 5'd9}) begin
            failures++;
            $display("FAIL areset_resume: valid=%0b data=%h tag=%0d required 1/0000000c/9", out_valid, out_data, out_tag);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            checks++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
                failures++;
                $display("FAIL rand_flags%0d: valid=%0b ready=%0b required %0b/%0b", c, out_valid, in_ready,
                         q.size() != 0, q.size() < 2);
            end else if (q.size() != 0 && {out_data, out_tag, out_illegal} !== {q[0].d, q[0].t, q[0].i}) begin
                failures++;
                $display("FAIL rand_head%0d: data=%h tag=%0d ill=%0b required %h/%0d/%0b", c, out_data, out_tag,
                         out_illegal, q[0].d, q[0].t, q[0].i);
            end
            step(($urandom % 4) != 0, 16'($urandom), 3'($urandom_range(0, 7)), TAG_W'($urandom),
                 ($urandom % 3) != 0, ($urandom % 25) == 0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_modes();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/imm_ext_stage.md
Name: imm_ext_stage

Overview:
- Parametrised, registered immediate-extension stage for the P7 pipeline.
- Takes an IN_W-bit immediate with an extension opcode and produces an OUT_W-bit operand.
- Adds a branch-offset mode, an illegal-op flag, a pass-through tag, valid/ready handshaking, a 2-entry output buffer and a pipeline flush for exception/interrupt squash.
- Sits between decode and the operand-select logic of the next stage.

Parameters:
- IN_W, 16, immediate input width (>=2, < OUT_W).
- OUT_W, 32, extended output width.
- TAG_W, 5, width of the opaque tag carried with each request (e.g. instruction slot/ID).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous squash of all buffered and incoming requests.
- in_valid  input  1  request present.
- in_ready  output  1  stage can accept a request this cycle.
- in_imm  input  IN_W  raw immediate.
- in_op  input  3  extension opcode.
- in_tag  input  TAG_W  tag returned unchanged with the result.
- out_valid  output  1  head result valid.
- out_ready  input  1  consumer accepts the head result.
- out_data  output  OUT_W  extended value.
- out_tag  output  TAG_W  tag of the head result.
- out_illegal  output  1  head request used an undefined opcode.

Behaviour:
Opcodes, computed combinationally at push time and stored:
- 0 sign: {(OUT_W-IN_W){imm[IN_W-1]}, imm}.
- 1 zero: {(OUT_W-IN_W){0}, imm}.
- 2 upper: {imm, (OUT_W-IN_W){0}}.
- 3 branch: sign-extended value shifted left 2, truncated to OUT_W.
- 4..7: data = 0, illegal = 1.
- Opcodes 0..3 set illegal = 0.

Buffer:
- 2 entries, FIFO order.
- count register in 0..2; head pointer 1 bit.
- push = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = (count != 2). It is a function of registered state only; there is no combinational path from out_ready or in_valid.
- out_valid = (count != 0). out_data, out_tag and out_illegal come from the head entry, and are stable while out_valid && !out_ready.

Transitions:
- push only: count+1.
- pop only: count-1, head advances.
- push && pop (only possible at count 1): count stays 1 and the new entry becomes head on the next cycle.
- Latency: a request pushed at edge k is presented with out_valid=1 in the cycle after edge k when the buffer was empty. There is no same-cycle bypass.
- Full (count 2): in_ready=0 and in_valid is ignored, including when out_ready=1 in the same cycle.
- Empty: out_valid=0; the values of out_data, out_tag and out_illegal are don't-care but must not be X after reset.

Flush:
- On an edge with flush=1, count goes to 0 and the head resets.
- A push or pop requested in the same cycle is discarded and not counted.
- Flush has priority over everything except reset.

Reset:
- Asynchronous assertion clears count, head and all entry storage to 0, immediately.
- Values during reset: out_valid=0, out_data=0, out_tag=0, out_illegal=0, in_ready=1.
- Deassertion is synchronous to clk at the integrator level; the block needs no internal synchroniser.
- Reset mid-transfer discards all buffered entries.

Width rules:
- All arithmetic is unsigned bit manipulation; there is no saturation.
- The branch mode drops the top 2 bits of the sign-extended value.

Test Plan:
- Reset, then single push of imm=16'h8001, op=0, tag=3, with out_ready=1: one cycle later out_data=32'hFFFF8001, out_tag=3, out_illegal=0; next cycle out_valid=0.
- Modes on imm=16'h8001: op1 gives 32'h00008001; op2 gives 32'h80010000; op3 gives 32'hFFFE0004; op5 gives data 0 with out_illegal=1.
- Backpressure: out_ready=0 and three back-to-back pushes (tags 1, 2, 3). Required: tags 1 and 2 accepted, in_ready=0 in the third cycle so tag 3 is held, and out data stays stable. Then out_ready=1 and the outputs drain in order 1, 2, 3 with no loss or duplication.
- Simultaneous push/pop at count 1, sustained for 10 cycles with out_ready=1 and in_valid=1: throughput is 1 per cycle, count stays 1, and ordering is preserved.
- Flush with count=2 and in_valid=1 in the same cycle: the next cycle has out_valid=0 and in_ready=1, and nothing from before the flush ever appears at the output.
- Assert reset_n=0 asynchronously mid-cycle while count=1: out_valid drops immediately without waiting for a clock edge, and all outputs are 0. After release, operation resumes normally.
